// File: rtl/grayscale_axis.sv
// RGB-to-grayscale AXI4-Stream converter with a two-stage valid/ready pipeline.
// An AXI4-Lite CTRL register enables conversion; when it is clear, pixels pass through untouched.
module grayscale_axis #(
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic [31:0]                     s_axis_tdata,
    input  logic                            s_axis_tuser,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [31:0]                     m_axis_tdata,
    output logic                            m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

    rd_state_t rd_state, rd_state_next;

    logic                          ctrl_enable;
    logic                          aw_held, w_held;
    logic [1:0]                    aw_sel_q;
    logic                          w_bit_q, w_strb0_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;

    logic        s1_valid, s1_enable, s1_user, s1_last;
    logic [31:0] s1_data;
    logic        s2_ready;
    logic [15:0] luma_sum;
    logic [7:0]  luma;
    logic [31:0] conv_data;
    logic        unused_bits;

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    // Address and data are captured independently; the register updates once both halves are held.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_sel_q      <= 2'd0;
            w_bit_q       <= 1'b0;
            w_strb0_q     <= 1'b0;
            ctrl_enable   <= 1'b0;
        end else begin
            s_axi_awready <= s_axi_awvalid && !s_axi_awready && !aw_held && !s_axi_bvalid;
            s_axi_wready  <= s_axi_wvalid && !s_axi_wready && !w_held && !s_axi_bvalid;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held  <= 1'b1;
                aw_sel_q <= s_axi_awaddr[3:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held    <= 1'b1;
                w_bit_q   <= s_axi_wdata[0];
                w_strb0_q <= s_axi_wstrb[0];
            end
            if (aw_held && w_held) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                if (aw_sel_q == REG_CTRL && w_strb0_q)
                    ctrl_enable <= w_bit_q;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            rd_state <= RD_IDLE;
        else
            rd_state <= rd_state_next;
    end

    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            RD_IDLE: if (s_axi_arvalid) rd_state_next = RD_ADDR;
            RD_ADDR: rd_state_next = RD_DATA;
            RD_DATA: if (s_axi_rready) rd_state_next = RD_IDLE;
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = (rd_state == RD_ADDR);
        s_axi_rvalid  = (rd_state == RD_DATA);
    end

    always_comb begin
        rd_mux = '0;
        case (s_axi_araddr[3:2])
            REG_CTRL:   rd_mux[0] = ctrl_enable;
            REG_STATUS: rd_mux[0] = s1_valid || m_axis_tvalid;
            default:    rd_mux = '0;
        endcase
    end

    // Read data is captured during the address handshake and held until the master takes it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            s_axi_rdata <= '0;
        else if (rd_state == RD_ADDR)
            s_axi_rdata <= rd_mux;
    end

    assign s2_ready      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !s1_valid || s2_ready;

    assign luma_sum  = 16'd77  * {8'd0, s1_data[23:16]}
                     + 16'd150 * {8'd0, s1_data[15:8]}
                     + 16'd29  * {8'd0, s1_data[7:0]};
    assign luma      = luma_sum[15:8];
    assign conv_data = s1_enable ? {8'h00, luma, luma, luma} : s1_data;

    // Stage 1 records ENABLE alongside the beat so a later CTRL write cannot affect it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid  <= 1'b0;
            s1_enable <= 1'b0;
            s1_user   <= 1'b0;
            s1_last   <= 1'b0;
            s1_data   <= '0;
        end else if (s_axis_tready) begin
            s1_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                s1_data   <= s_axis_tdata;
                s1_enable <= ctrl_enable;
                s1_user   <= s_axis_tuser;
                s1_last   <= s_axis_tlast;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (s2_ready) begin
            m_axis_tvalid <= s1_valid;
            if (s1_valid) begin
                m_axis_tdata <= conv_data;
                m_axis_tuser <= s1_user;
                m_axis_tlast <= s1_last;
            end
        end
    end

    assign unused_bits = &{1'b0, s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_wstrb, luma_sum[7:0]};

endmodule

// File: tb/tb_grayscale_axis.sv
// Self-checking bench for grayscale_axis: register access, fixed pixel vectors,
// randomized backpressure against a luma reference model, and mid-stream reset.
module tb_grayscale_axis;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tuser, s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;

    typedef struct { logic [31:0] data; logic user; logic last; } beat_t;
    typedef struct { logic [31:0] tdata; logic enable; logic [31:0] expected; } vec_t;

    beat_t  exp_q[$];
    beat_t  out_log[$];
    vec_t   vecs[9];
    int     check_count = 0;
    int     pass_count = 0;
    int     in_count = 0;
    int     out_count = 0;
    int     beats_sent = 0;
    int     wait_n;
    int     lasts, users;
    longint t0;
    logic   model_enable = 1'b0;
    logic   pending_enable = 1'b0;
    logic   stall_prev = 1'b0;
    logic   rand_done = 1'b0;
    beat_t  held;
    beat_t  got, want;

    grayscale_axis dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    always #5 aclk = ~aclk;

    // Luma from the weighted-average definition, in plain integer arithmetic.
    function automatic logic [31:0] model_pixel(input logic [31:0] px, input logic en);
        int y;
        if (!en) return px;
        y = (77 * int'(px[23:16]) + 150 * int'(px[15:8]) + 29 * int'(px[7:0])) / 256;
        return {8'h00, 8'(y), 8'(y), 8'(y)};
    endfunction

    task automatic check32(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic record_fail(input string name);
        check_count++;
        $display("[TB] FAIL %s: event did not occur within its cycle budget", name);
    endtask

    // Scoreboard: every accepted input beat is predicted, every output beat is checked in order.
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (s_axi_bvalid) model_enable = pending_enable;
            if (stall_prev) begin
                check32("stall_hold_data", m_axis_tdata, held.data);
                check32("stall_hold_flags", {29'b0, m_axis_tvalid, m_axis_tuser, m_axis_tlast},
                        {29'b0, 1'b1, held.user, held.last});
            end
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back(beat_t'{model_pixel(s_axis_tdata, model_enable), s_axis_tuser, s_axis_tlast});
                in_count++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got = '{m_axis_tdata, m_axis_tuser, m_axis_tlast};
                out_log.push_back(got);
                out_count++;
                if (exp_q.size() == 0) begin
                    record_fail("unexpected_output_beat");
                end else begin
                    want = exp_q.pop_front();
                    check32("stream_data", got.data, want.data);
                    check32("stream_flags", {30'b0, got.user, got.last}, {30'b0, want.user, want.last});
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held = '{m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    task automatic applyStimulus(input logic [31:0] data, input logic user, input logic last);
        int n;
        s_axis_tdata  = data;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_axis_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!s_axis_tready) begin
            record_fail("input_accept");
            s_axis_tvalid = 1'b0;
        end
        @(posedge aclk); #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [31:0] expected);
        int n;
        n = 0;
        while (out_log.size() <= idx && n < 100) begin
            @(negedge aclk); #1;
            n++;
        end
        if (out_log.size() <= idx) record_fail(name);
        else check32(name, out_log[idx].data, expected);
        @(posedge aclk); #1;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb, input int order);
        int n;
        bit aw_done, w_done, aw_hs, w_hs;
        if (addr[3:2] == 2'd0 && strb[0]) pending_enable = data[0];
        aw_done = 0;
        w_done  = 0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_bready  = 1'b1;
        s_axi_awvalid = (order != 2);
        s_axi_wvalid  = (order != 1);
        n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge aclk);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(posedge aclk); #1;
            if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_axi_wvalid = 1'b0;  end
            if (aw_done && !w_done && !s_axi_wvalid) s_axi_wvalid = 1'b1;
            if (w_done && !aw_done && !s_axi_awvalid) s_axi_awvalid = 1'b1;
            n++;
        end
        if (!(aw_done && w_done)) begin
            record_fail("write_handshake");
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
        end
        n = 0;
        @(negedge aclk);
        while (!s_axi_bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (s_axi_bvalid) check32("write_bresp", {30'b0, s_axi_bresp}, 32'h0);
        else record_fail("write_bvalid");
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input string name, input logic [3:0] addr, input logic [31:0] expected);
        int n;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_axi_arready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!s_axi_arready) begin
            record_fail(name);
            s_axi_arvalid = 1'b0;
            @(posedge aclk); #1;
            return;
        end
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_axi_rvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (s_axi_rvalid) begin
            check32(name, s_axi_rdata, expected);
            check32({name, "_rresp"}, {30'b0, s_axi_rresp}, 32'h0);
        end else begin
            record_fail(name);
        end
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h00FFFFFF, 1'b1, 32'h00FFFFFF};
        vecs[1] = '{32'h00FF0000, 1'b1, 32'h004C4C4C};
        vecs[2] = '{32'h0000FF00, 1'b1, 32'h00959595};
        vecs[3] = '{32'h000000FF, 1'b1, 32'h001C1C1C};
        vecs[4] = '{32'hFF000000, 1'b1, 32'h00000000};
        vecs[5] = '{32'h00808080, 1'b1, 32'h00808080};
        vecs[6] = '{32'hAB123456, 1'b0, 32'hAB123456};
        vecs[7] = '{32'h00FF0000, 1'b0, 32'h00FF0000};
        vecs[8] = '{32'h12345678, 1'b1, 32'h004F4F4F};

        aresetn = 1'b0;
        s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b1; s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF;
        s_axi_wvalid = 1'b1; s_axi_bready = 1'b0; s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
        s_axi_rready = 1'b0;
        s_axis_tdata = 32'hFFFFFFFF; s_axis_tuser = 1'b1; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        check32("reset_valids", {26'b0, m_axis_tvalid, s_axi_bvalid, s_axi_rvalid,
                                 s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
        check32("reset_tdata", m_axis_tdata, 32'h0);
        check32("reset_tflags", {30'b0, m_axis_tuser, m_axis_tlast}, 32'h0);

        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0; s_axis_tvalid = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        $display("[TB] register access");
        axi_read("ctrl_after_reset", 4'h0, 32'h0);
        axi_write(4'h0, 32'h1, 4'hF, 0);
        axi_read("ctrl_enabled", 4'h0, 32'h1);
        axi_read("status_idle", 4'h4, 32'h0);
        axi_read("unmapped_read", 4'h8, 32'h0);
        axi_write(4'h0, 32'h0, 4'hE, 1);
        axi_read("ctrl_strb_masked", 4'h0, 32'h1);
        axi_write(4'hC, 32'h0, 4'hF, 2);
        axi_read("ctrl_after_unmapped_write", 4'h0, 32'h1);

        $display("[TB] fixed pixel vectors");
        out_log.delete();
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].enable !== pending_enable)
                axi_write(4'h0, {31'b0, vecs[i].enable}, 4'hF, i % 3);
            applyStimulus(vecs[i].tdata, 1'b0, 1'b1);
            s_axis_tvalid = 1'b0;
            checkOutput($sformatf("vector_%0d", i), i, vecs[i].expected);
        end

        $display("[TB] latency");
        applyStimulus(32'h00102030, 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        check32("latency_cycle1", {31'b0, m_axis_tvalid}, 32'h0);
        @(negedge aclk);
        check32("latency_cycle2", {31'b0, m_axis_tvalid}, 32'h1);
        @(posedge aclk); #1;

        $display("[TB] 100-beat line");
        axi_write(4'h0, 32'h1, 4'hF, 1);
        repeat (3) @(posedge aclk);
        #1;
        out_log.delete();
        t0 = $time;
        for (int i = 0; i < 100; i++)
            applyStimulus(32'(i), 1'b1, i == 99);
        check32("throughput_cycles", 32'(($time - t0) / 10), 32'd100);
        s_axis_tvalid = 1'b0;
        wait_n = 0;
        while (out_log.size() < 100 && wait_n < 50) begin
            @(posedge aclk); #1;
            wait_n++;
        end
        repeat (3) @(posedge aclk);
        #1;
        check32("line_beat_count", 32'(out_log.size()), 32'd100);
        if (out_log.size() >= 100) begin
            lasts = 0;
            users = 0;
            foreach (out_log[k]) begin
                lasts += int'(out_log[k].last);
                users += int'(out_log[k].user);
            end
            check32("line_beat0", out_log[0].data, 32'h00000000);
            check32("line_beat99", out_log[99].data, 32'h000B0B0B);
            check32("line_tlast_count", 32'(lasts), 32'd1);
            check32("line_tlast_pos", {31'b0, out_log[99].last}, 32'h1);
            check32("line_tuser_count", 32'(users), 32'd100);
        end

        $display("[TB] ENABLE cleared while beats are stalled");
        m_axis_tready = 1'b0;
        out_log.delete();
        applyStimulus(32'h00FF0000, 1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        axi_write(4'h0, 32'h0, 4'hF, 0);
        applyStimulus(32'h00FF0000, 1'b0, 1'b1);
        s_axis_tvalid = 1'b0;
        axi_read("status_busy", 4'h4, 32'h1);
        m_axis_tready = 1'b1;
        checkOutput("clear_before_write", 0, 32'h004C4C4C);
        checkOutput("clear_after_write", 1, 32'h00FF0000);

        $display("[TB] randomized backpressure");
        axi_write(4'h0, 32'h1, 4'hF, 2);
        beats_sent = 0;
        rand_done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        s_axis_tvalid = 1'b0;
                        @(posedge aclk); #1;
                    end
                    applyStimulus($urandom, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
                    beats_sent++;
                end
                s_axis_tvalid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    m_axis_tready = ($urandom_range(0, 9) < 7);
                    @(posedge aclk); #1;
                end
                m_axis_tready = 1'b1;
            end
            begin
                wait_n = 0;
                while (beats_sent < 500 && wait_n < 5000) begin
                    @(posedge aclk); #1;
                    wait_n++;
                end
                axi_write(4'h0, 32'h0, 4'hF, 0);
            end
        join
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 100) begin
            @(posedge aclk); #1;
            wait_n++;
        end
        check32("random_drain_empty", 32'(exp_q.size()), 32'd0);
        check32("random_in_out_count", 32'(out_count), 32'(in_count));
        axi_read("ctrl_cleared_midstream", 4'h0, 32'h0);

        $display("[TB] reset mid-stream");
        axi_write(4'h0, 32'h1, 4'hF, 0);
        m_axis_tready = 1'b0;
        applyStimulus(32'h11223344, 1'b1, 1'b0);
        applyStimulus(32'h55667788, 1'b0, 1'b1);
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check32("midreset_valids", {29'b0, m_axis_tvalid, s_axi_bvalid, s_axi_rvalid}, 32'h0);
        check32("midreset_tdata", m_axis_tdata, 32'h0);
        check32("midreset_tready", {31'b0, s_axis_tready}, 32'h1);
        exp_q.delete();
        pending_enable = 1'b0;
        model_enable   = 1'b0;
        in_count  = 0;
        out_count = 0;
        @(posedge aclk);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        axi_read("ctrl_after_midreset", 4'h0, 32'h0);
        out_log.delete();
        applyStimulus(32'hAB123456, 1'b1, 1'b1);
        s_axis_tvalid = 1'b0;
        checkOutput("post_reset_passthrough", 0, 32'hAB123456);
        repeat (4) @(posedge aclk);
        #1;
        check32("post_reset_beat_count", 32'(out_log.size()), 32'd1);
        check32("final_in_out_count", 32'(out_count), 32'(in_count));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
